// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state type and sizing helper for backplane bus controllers
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ADDR,
        DATA,
        RELEASE
    } bus_state_t;

    // Counter only has to reach cycles-1, so clog2 of the limit is enough.
    function automatic int timeout_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first set request after ptr_i with wrap
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] cand;

    // Walk from the farthest candidate inward so the nearest one after ptr_i wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = N; i >= 1; i--) begin
            cand = W'((32'(ptr_i) + 32'(i)) % 32'(N));
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_grant_scheduler.sv
// rtl/bus_grant_scheduler.sv - round-robin backplane arbiter with phase tracking and timeout abort
module bus_grant_scheduler
    import bus_arb_pkg::*;
#(
    parameter int DeviceMaxNumber = 4,
    parameter int TimeoutCycles   = 64
) (
    input  logic                               clk,
    input  logic                               Reset,
    input  logic [DeviceMaxNumber-1:0]         BARQ,
    input  logic                               AddressValid,
    input  logic                               TargetReady,
    input  logic                               DataStrobe,
    output logic [DeviceMaxNumber-1:0]         BAGD,
    output logic                               BusBusy,
    output logic [$clog2(DeviceMaxNumber)-1:0] GrantId,
    output logic                               Error
);

    localparam int              IdW     = $clog2(DeviceMaxNumber);
    localparam int              CntW    = timeout_cnt_width(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    bus_state_t                 state_q, state_d;
    logic [IdW-1:0]             ptr_q, ptr_d;
    logic [IdW-1:0]             id_q, id_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [DeviceMaxNumber-1:0] bagd_q, bagd_d;
    logic                       err_q, err_d;
    logic                       pick_valid;
    logic [IdW-1:0]             pick_idx;
    logic                       owner_req;
    logic                       expired;
    logic                       timeout;

    rr_pick #(
        .N(DeviceMaxNumber),
        .W(IdW)
    ) u_pick (
        .req_i  (BARQ),
        .ptr_i  (ptr_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            ptr_q   <= IdW'(DeviceMaxNumber - 1);
            id_q    <= '0;
            cnt_q   <= '0;
            bagd_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            bagd_q  <= bagd_d;
            err_q   <= err_d;
        end
    end

    assign owner_req = BARQ[id_q];
    assign expired   = (cnt_q == CntLast);

    // Request withdrawal outranks phase progress; progress outranks the timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q + CntW'(1);
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    ptr_d   = pick_idx;
                    id_d    = pick_idx;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_d = RELEASE;
                end else if (AddressValid) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d = RELEASE;
                    timeout = 1'b1;
                end
            end
            ADDR: begin
                if (!owner_req) begin
                    state_d = RELEASE;
                end else if (TargetReady) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d = RELEASE;
                    timeout = 1'b1;
                end
            end
            DATA: begin
                if (!owner_req) begin
                    state_d = RELEASE;
                end else if (DataStrobe) begin
                    cnt_d = '0;
                end else if (expired) begin
                    state_d = RELEASE;
                    timeout = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bagd_d = bagd_q;
        err_d  = timeout;
        if (state_q == IDLE && pick_valid) begin
            bagd_d           = '0;
            bagd_d[pick_idx] = 1'b1;
        end else if (state_d == RELEASE) begin
            bagd_d = '0;
        end
    end

    assign BAGD    = bagd_q;
    assign GrantId = id_q;
    assign Error   = err_q;
    assign BusBusy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// tb/tb_bus_grant_scheduler.sv - directed and randomized bench for bus_grant_scheduler
module tb_bus_grant_scheduler;

    localparam int N = 4;
    localparam int T = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] barq;
    logic         av;
    logic         tr;
    logic         ds;
    logic [N-1:0] BAGD;
    logic         BusBusy;
    logic [1:0]   GrantId;
    logic         Error;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference: who owns the bus, which phase it is waiting on, how long it has stalled.
    int m_owner;
    int m_stage;
    int m_wait;
    bit m_turn;
    int m_last;
    int m_id;
    bit m_err;

    bus_grant_scheduler #(
        .DeviceMaxNumber(N),
        .TimeoutCycles  (T)
    ) dut (
        .clk         (clk),
        .Reset       (rst_n),
        .BARQ        (barq),
        .AddressValid(av),
        .TargetReady (tr),
        .DataStrobe  (ds),
        .BAGD        (BAGD),
        .BusBusy     (BusBusy),
        .GrantId     (GrantId),
        .Error       (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        bit progress;
        m_err = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_turn  = 1'b0;
            m_last  = N - 1;
            m_id    = 0;
            m_wait  = 0;
            return;
        end
        if (m_turn) begin
            m_turn = 1'b0;
            return;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (barq[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_id    = c;
                    m_stage = 0;
                    m_wait  = 0;
                    break;
                end
            end
            return;
        end
        if (!barq[m_owner]) begin
            m_owner = -1;
            m_turn  = 1'b1;
            return;
        end
        case (m_stage)
            0:       progress = av;
            1:       progress = tr;
            default: progress = ds;
        endcase
        if (progress) begin
            if (m_stage < 2) m_stage++;
            m_wait = 0;
            return;
        end
        m_wait++;
        if (m_wait == T) begin
            m_err   = 1'b1;
            m_owner = -1;
            m_turn  = 1'b1;
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eb;
        logic [1:0]   ei;
        logic         ebusy;
        eb = '0;
        if (m_owner >= 0) eb[m_owner] = 1'b1;
        ei    = 2'(m_id);
        ebusy = (m_owner >= 0) || m_turn;
        checks++;
        assert (BAGD === eb) passes++;
        else begin fails++; $error("FAIL %s_bagd got %b expected %b", tag, BAGD, eb); end
        checks++;
        assert (GrantId === ei) passes++;
        else begin fails++; $error("FAIL %s_id got %0d expected %0d", tag, GrantId, ei); end
        checks++;
        assert (BusBusy === ebusy) passes++;
        else begin fails++; $error("FAIL %s_busy got %b expected %b", tag, BusBusy, ebusy); end
        checks++;
        assert (Error === m_err) passes++;
        else begin fails++; $error("FAIL %s_err got %b expected %b", tag, Error, m_err); end
    endtask

    task automatic cyc(input string tag = "cyc");
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 8 && id < 0; i++) begin
            cyc("wg");
            if (BAGD != '0) id = int'(GrantId);
        end
        check_val("grant_seen", int'(id >= 0), 1);
    endtask

    task automatic count_to_error(input string tag, input int exp);
        int got;
        got = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(tag);
            if (Error === 1'b1) begin
                got = i;
                break;
            end
        end
        check_val(tag, got, exp);
    endtask

    initial begin
        int id;
        int errs;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; barq = 4'b1111; av = 1'b0; tr = 1'b0; ds = 1'b0;
        m_owner = -1; m_stage = 0; m_wait = 0; m_turn = 1'b0;
        m_last = N - 1; m_id = 0; m_err = 1'b0;

        // Reset with all requests pending, then first grant goes to master 0.
        cyc("rst");
        cyc("rst");
        rst_n = 1'b1;
        cyc("t1");
        check_val("t1_bagd", int'(BAGD), 1);

        // Fairness with all four requesting.
        for (int t = 0; t < 5; t++) begin
            if (t == 0) id = int'(GrantId);
            else wait_grant(id);
            check_val("t2_order", id, exp_order[t]);
            if (id < 0) break;
            av = 1'b1; cyc("t2"); av = 1'b0;
            tr = 1'b1; cyc("t2"); tr = 1'b0;
            ds = 1'b1; cyc("t2"); cyc("t2"); ds = 1'b0;
            barq[id] = 1'b0; cyc("t2"); barq[id] = 1'b1;
        end
        barq = '0;
        cyc("t2"); cyc("t2"); cyc("t2");

        // Master 2 withdraws before address; master 3 follows.
        barq = 4'b1100;
        wait_grant(id);
        check_val("t3_first", id, 2);
        barq[2] = 1'b0;
        cyc("t3");
        check_val("t3_rel_bagd", int'(BAGD), 0);
        wait_grant(id);
        check_val("t3_next", id, 3);
        barq = '0;
        cyc("t3"); cyc("t3");

        // Address accepted but target never ready.
        barq = 4'b0010;
        wait_grant(id);
        check_val("t4_id", id, 1);
        av = 1'b1; cyc("t4"); av = 1'b0;
        count_to_error("t4_timeout", T);
        check_val("t4_bagd", int'(BAGD), 0);
        barq = '0;
        cyc("t4"); cyc("t4");

        // Data phase kept alive by strobes, then left to expire.
        barq = 4'b0001;
        wait_grant(id);
        check_val("t5_id", id, 0);
        av = 1'b1; cyc("t5"); av = 1'b0;
        tr = 1'b1; cyc("t5"); tr = 1'b0;
        errs = 0;
        for (int i = 1; i <= 42; i++) begin
            ds = (i % 7 == 0);
            cyc("t5");
            if (Error === 1'b1) errs++;
        end
        ds = 1'b0;
        check_val("t5_keepalive_errs", errs, 0);
        count_to_error("t5_timeout", T);
        barq = '0;
        cyc("t5"); cyc("t5");

        // Reset in the middle of a data phase.
        barq = 4'b0100;
        wait_grant(id);
        av = 1'b1; cyc("t6"); av = 1'b0;
        tr = 1'b1; cyc("t6"); tr = 1'b0;
        cyc("t6");
        check_val("t6_bagd_data", int'(BAGD), 4);
        rst_n = 1'b0; barq = 4'b1111;
        cyc("t6");
        check_val("t6_rst_bagd", int'(BAGD), 0);
        check_val("t6_rst_busy", int'(BusBusy), 0);
        check_val("t6_rst_err", int'(Error), 0);
        rst_n = 1'b1;
        cyc("t6");
        check_val("t6_regrant", int'(BAGD), 1);
        barq = '0;
        cyc("t6"); cyc("t6");

        // Randomized traffic against the reference.
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) barq[b] = ~barq[b];
            end
            av    = ($urandom_range(0, 3) == 0);
            tr    = ($urandom_range(0, 3) == 0);
            ds    = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc("rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
